// File: rtl/mem_ctrl_if.sv
// ---------------------------------------------------------------------------
// mem_ctrl_if
// Host-side request/data interface of the burst memory controller.
//
//   reqValid  host -> ctrl  request valid
//   reqRead   host -> ctrl  1 = read burst, 0 = write burst
//   reqAddr   host -> ctrl  burst base address
//   reqReady  ctrl -> host  controller can accept a request
//   wrData    host -> ctrl  write word for the current beat
//   wrDataReq ctrl -> host  host must present the current beat's word now
//   rdData    ctrl -> host  registered read word
//   rdValid   ctrl -> host  rdData holds a valid word this cycle
//   done      ctrl -> host  one-cycle burst-complete pulse
//
// master = host side, slave = controller side.
// ---------------------------------------------------------------------------
interface mem_ctrl_if #(
    parameter int DATAWIDTH = 16,
    parameter int ADDRWIDTH = 8
);
    logic                 reqValid;
    logic                 reqRead;
    logic [ADDRWIDTH-1:0] reqAddr;
    logic                 reqReady;
    logic [DATAWIDTH-1:0] wrData;
    logic                 wrDataReq;
    logic [DATAWIDTH-1:0] rdData;
    logic                 rdValid;
    logic                 done;

    modport master (
        output reqValid, reqRead, reqAddr, wrData,
        input  reqReady, wrDataReq, rdData, rdValid, done
    );

    modport slave (
        input  reqValid, reqRead, reqAddr, wrData,
        output reqReady, wrDataReq, rdData, rdValid, done
    );
endinterface

// File: rtl/mem_ctrl.sv
// ---------------------------------------------------------------------------
// mem_ctrl
// Initiator-side controller for a synchronous single-port memory with a
// tristate data bus. Accepts burst read/write requests from a host and runs
// BURSTLEN consecutive memory accesses starting at the requested address
// (address wraps modulo 2^ADDRWIDTH).
//
// Ports:
//   clk     input   system clock, rising edge
//   resetN  input   synchronous active-low reset
//   host    slave   host request/data interface (see mem_ctrl_if)
//   rdEn    output  memory read enable
//   wrEn    output  memory write enable
//   Addr    output  memory address
//   Data    inout   tristate memory data bus, driven only in write beats
// ---------------------------------------------------------------------------
module mem_ctrl #(
    parameter int MEMDEPTH  = 256,
    parameter int DATAWIDTH = 16,
    parameter int ADDRWIDTH = $clog2(MEMDEPTH),
    parameter int BURSTLEN  = 4
) (
    input  logic                 clk,
    input  logic                 resetN,
    mem_ctrl_if.slave            host,
    output logic                 rdEn,
    output logic                 wrEn,
    output logic [ADDRWIDTH-1:0] Addr,
    inout  wire  [DATAWIDTH-1:0] Data
);

    localparam int                BEATW     = $clog2(BURSTLEN) + 1;
    localparam logic [BEATW-1:0]  LAST_BEAT = BEATW'(BURSTLEN - 1);

    if (BURSTLEN < 1 || BURSTLEN > 16) begin : g_bad_burstlen
        $error("mem_ctrl: BURSTLEN must be within 1..16");
    end
    if (MEMDEPTH > (2 ** ADDRWIDTH)) begin : g_bad_depth
        $error("mem_ctrl: ADDRWIDTH too narrow for MEMDEPTH");
    end

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        WRITE = 2'd2
    } state_t;

    state_t               state_q;
    logic [BEATW-1:0]     beat_q;
    logic [ADDRWIDTH-1:0] base_q;
    logic [DATAWIDTH-1:0] rdData_q;
    logic                 rdValid_q;
    logic                 done_q;
    logic [ADDRWIDTH-1:0] beatExt;

    always_ff @(posedge clk) begin
        if (!resetN) begin
            state_q   <= IDLE;
            beat_q    <= '0;
            base_q    <= '0;
            rdData_q  <= '0;
            rdValid_q <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            rdValid_q <= 1'b0;
            done_q    <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (host.reqValid) begin
                        base_q  <= host.reqAddr;
                        beat_q  <= '0;
                        state_q <= host.reqRead ? READ : WRITE;
                    end
                end
                READ, WRITE: begin
                    // Memory read data is combinational from Addr, so the
                    // bus already carries this beat's word at the edge.
                    if (state_q == READ) begin
                        rdData_q  <= Data;
                        rdValid_q <= 1'b1;
                    end
                    if (beat_q == LAST_BEAT) begin
                        state_q <= IDLE;
                        beat_q  <= '0;
                        done_q  <= 1'b1;
                    end else begin
                        beat_q <= beat_q + 1'b1;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    beat_q  <= '0;
                end
            endcase
        end
    end

    // Moore decode of the memory side from registered state only.
    assign beatExt = ADDRWIDTH'(beat_q);
    assign rdEn    = (state_q == READ);
    assign wrEn    = (state_q == WRITE);
    assign Addr    = (state_q == IDLE) ? '0 : base_q + beatExt;
    assign Data    = (state_q == WRITE) ? host.wrData : {DATAWIDTH{1'bz}};

    assign host.reqReady  = (state_q == IDLE);
    assign host.wrDataReq = (state_q == WRITE);
    assign host.rdData    = rdData_q;
    assign host.rdValid   = rdValid_q;
    assign host.done      = done_q;

endmodule

// File: tb/tb_mem_ctrl.sv
// ---------------------------------------------------------------------------
// tb_mem_ctrl
// Bench for mem_ctrl: a simple behavioural memory sits on rdEn/wrEn/Addr/Data,
// and a word-level reference array tracks what every host burst should have
// left in memory. Inputs change and outputs are sampled on the falling edge.
// ---------------------------------------------------------------------------
module tb_mem_ctrl;

    localparam int DW = 16;
    localparam int AW = 8;
    localparam int BL = 4;

    logic          clk;
    logic          resetN;
    logic          rdEn;
    logic          wrEn;
    logic [AW-1:0] Addr;
    wire  [DW-1:0] Data;

    mem_ctrl_if #(.DATAWIDTH(DW), .ADDRWIDTH(AW)) hif ();

    mem_ctrl #(
        .MEMDEPTH (256),
        .DATAWIDTH(DW),
        .ADDRWIDTH(AW),
        .BURSTLEN (BL)
    ) dut (
        .clk   (clk),
        .resetN(resetN),
        .host  (hif.slave),
        .rdEn  (rdEn),
        .wrEn  (wrEn),
        .Addr  (Addr),
        .Data  (Data)
    );

    // Attached memory: combinational read, write captured at the clock edge.
    logic [DW-1:0] mem [256];
    logic          mem_clr;

    always @(posedge clk) begin
        if (mem_clr) begin
            for (int k = 0; k < 256; k++) mem[k] <= '0;
        end else if (wrEn) begin
            mem[Addr] <= Data;
        end
    end
    assign Data = rdEn ? mem[Addr] : {DW{1'bz}};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: expected memory contents, updated per host burst.
    logic [DW-1:0] ref_mem [256];
    logic [DW-1:0] wq [BL];

    int n_vec;
    int n_err;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Quiet cycles with no request.
    task automatic idle(input int n);
        hif.reqValid = 1'b0;
        for (int c = 0; c < n; c++) begin
            @(negedge clk);
            chk("idle_ready", {31'd0, hif.reqReady}, 32'd1);
            chk("idle_en", {30'd0, rdEn, wrEn}, 32'd0);
            chk("idle_addr", {24'd0, Addr}, 32'd0);
            chk("idle_done", {31'd0, hif.done}, 32'd0);
            chk("idle_rdvalid", {31'd0, hif.rdValid}, 32'd0);
        end
    endtask

    // One burst issued at the current falling edge; returns at the falling
    // edge of the done cycle so a following call is back-to-back.
    task automatic burst(input bit rd, input logic [AW-1:0] a, input bit hold);
        logic [DW-1:0] e [BL];
        logic [AW-1:0] ai;
        chk("req_ready", {31'd0, hif.reqReady}, 32'd1);
        hif.reqValid = 1'b1;
        hif.reqRead  = rd;
        hif.reqAddr  = a;
        for (int i = 0; i < BL; i++) begin
            @(negedge clk);
            if (hold) begin
                hif.reqValid = 1'b1;
                hif.reqRead  = 1'($urandom);
                hif.reqAddr  = AW'($urandom);
            end else begin
                hif.reqValid = 1'b0;
            end
            ai = a + AW'(i);
            chk("beat_ready", {31'd0, hif.reqReady}, 32'd0);
            chk("beat_rden", {31'd0, rdEn}, {31'd0, rd});
            chk("beat_wren", {31'd0, wrEn}, {31'd0, !rd});
            chk("beat_addr", {24'd0, Addr}, {24'd0, ai});
            chk("beat_wrreq", {31'd0, hif.wrDataReq}, {31'd0, !rd});
            chk("beat_done", {31'd0, hif.done}, 32'd0);
            if (rd && i > 0) begin
                chk("beat_rdvalid", {31'd0, hif.rdValid}, 32'd1);
                chk("beat_rddata", {16'd0, hif.rdData}, {16'd0, e[i-1]});
            end else begin
                chk("beat_rdvalid", {31'd0, hif.rdValid}, 32'd0);
            end
            if (rd) e[i] = ref_mem[ai];
            else    hif.wrData = wq[i];
        end
        @(negedge clk);
        chk("end_done", {31'd0, hif.done}, 32'd1);
        chk("end_ready", {31'd0, hif.reqReady}, 32'd1);
        chk("end_en", {30'd0, rdEn, wrEn}, 32'd0);
        chk("end_addr", {24'd0, Addr}, 32'd0);
        chk("end_wrreq", {31'd0, hif.wrDataReq}, 32'd0);
        chk("end_rdvalid", {31'd0, hif.rdValid}, {31'd0, rd});
        if (rd) chk("end_rddata", {16'd0, hif.rdData}, {16'd0, e[BL-1]});
        hif.reqValid = 1'b0;
        if (!rd) begin
            for (int i = 0; i < BL; i++) ref_mem[AW'(a + AW'(i))] = wq[i];
        end
    endtask

    task automatic rand_words();
        for (int i = 0; i < BL; i++) wq[i] = DW'($urandom);
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;
        for (int k = 0; k < 256; k++) ref_mem[k] = '0;
        for (int i = 0; i < BL; i++) wq[i] = '0;
        hif.wrData = '0;

        // Reset held for two edges with a request pending: nothing may start.
        mem_clr      = 1'b1;
        resetN       = 1'b0;
        hif.reqValid = 1'b1;
        hif.reqRead  = 1'b1;
        hif.reqAddr  = 8'h33;
        repeat (2) @(negedge clk);
        mem_clr      = 1'b0;
        resetN       = 1'b1;
        hif.reqValid = 1'b0;
        chk("rst_ready", {31'd0, hif.reqReady}, 32'd1);
        chk("rst_en", {30'd0, rdEn, wrEn}, 32'd0);
        chk("rst_rdvalid", {31'd0, hif.rdValid}, 32'd0);
        chk("rst_done", {31'd0, hif.done}, 32'd0);
        chk("rst_rddata", {16'd0, hif.rdData}, 32'd0);
        idle(2);

        // Directed write then read-back at 0x10.
        wq[0] = 16'hA001; wq[1] = 16'hA002; wq[2] = 16'hA003; wq[3] = 16'hA004;
        burst(1'b0, 8'h10, 1'b0);
        for (int i = 0; i < BL; i++)
            chk("mem_word", {16'd0, mem[8'h10 + 8'(i)]}, {16'd0, wq[i]});
        idle(1);
        burst(1'b1, 8'h10, 1'b0);
        idle(1);

        // Address wrap through 0xFF -> 0x00.
        wq[0] = 16'h1111; wq[1] = 16'h2222; wq[2] = 16'h3333; wq[3] = 16'h4444;
        burst(1'b0, 8'hFE, 1'b0);
        idle(1);
        burst(1'b1, 8'hFE, 1'b0);
        idle(1);

        // Reset in the middle of a read: no done, then a clean re-read.
        rand_words();
        burst(1'b0, 8'h20, 1'b0);
        idle(1);
        hif.reqValid = 1'b1;
        hif.reqRead  = 1'b1;
        hif.reqAddr  = 8'h20;
        @(negedge clk);
        hif.reqValid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        resetN = 1'b0;
        @(negedge clk);
        resetN = 1'b1;
        chk("mrst_rden", {31'd0, rdEn}, 32'd0);
        chk("mrst_ready", {31'd0, hif.reqReady}, 32'd1);
        chk("mrst_done", {31'd0, hif.done}, 32'd0);
        chk("mrst_rdvalid", {31'd0, hif.rdValid}, 32'd0);
        idle(3);
        burst(1'b1, 8'h20, 1'b0);
        idle(1);

        // Back-to-back with reqValid held high through the bursts.
        rand_words();
        burst(1'b0, 8'h40, 1'b1);
        burst(1'b1, 8'h40, 1'b1);
        idle(1);

        // Randomised bursts, gaps and holds.
        for (int n = 0; n < 40; n++) begin
            logic [AW-1:0] ra;
            ra = ($urandom_range(0, 3) == 0) ? AW'(8'hFC + 8'($urandom_range(0, 3)))
                                             : AW'($urandom);
            rand_words();
            burst(1'($urandom), ra, 1'($urandom));
            idle($urandom_range(0, 2));
        end
        idle(1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
